// File: rtl/prog_loader_pkg.sv
// Shared types and sizing constants for the program loader and the
// instruction memory it feeds.
package prog_loader_pkg;

    localparam int BYTE_W            = 8;
    localparam int BYTE_IDX_W        = $clog2(BYTE_W);
    localparam int DEFAULT_PROG_BITS = 256;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        CHECK,
        FINISH
    } state_t;

endpackage

// File: rtl/prog_bit_serializer.sv
// Byte-wide load/shift register that hands out one bit per shift, in either
// bit order, and flags when the bit being presented is the byte's last.
module prog_bit_serializer
    import prog_loader_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              load,
    input  logic              shift,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              bit_out,
    output logic              byte_last
);

    logic [BYTE_W-1:0]     sreg_q, sreg_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            sreg_q <= '0;
            idx_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            idx_q  <= idx_d;
        end
    end

    always_comb begin
        sreg_d = sreg_q;
        idx_d  = idx_q;
        if (load) begin
            sreg_d = byte_in;
            idx_d  = '0;
        end else if (shift) begin
            sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
            idx_d  = idx_q + BYTE_IDX_W'(1);
        end
    end

    always_comb begin
        bit_out   = LSB_FIRST ? sreg_q[0] : sreg_q[BYTE_W-1];
        byte_last = (idx_q == BYTE_IDX_W'(BYTE_W - 1));
    end

endmodule

// File: rtl/prog_loader.sv
// Host byte stream to instruction-memory bit stream loader.
// Define PROG_LOADER_CHECKSUM_EN to require an XOR trailer byte after the program.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int PROG_BITS = DEFAULT_PROG_BITS,
    parameter bit LSB_FIRST = 1'b1,
    parameter int BIT_CNT_W = $clog2(PROG_BITS + 1)
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              byte_ready,
    output logic              prog_enable,
    output logic              prog_advance,
    output logic              prog_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [BIT_CNT_W-1:0] CNT_LAST = BIT_CNT_W'(PROG_BITS);

    state_t               state_q, state_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 error_q, error_d;
    logic                 done_q, done_d;
    logic                 enable_q, enable_d;
    logic                 handshake;
    logic                 ser_load, ser_shift, ser_bit, ser_last;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0]    csum_q, csum_d;
`endif

    prog_bit_serializer #(
        .LSB_FIRST (LSB_FIRST)
    ) u_serializer (
        .clock     (clock),
        .rst_n     (rst_n),
        .load      (ser_load),
        .shift     (ser_shift),
        .byte_in   (byte_in),
        .bit_out   (ser_bit),
        .byte_last (ser_last)
    );

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
            enable_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            error_q  <= error_d;
            done_q   <= done_d;
            enable_q <= enable_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    // Abort masks the handshake and the strobe in the same cycle so the host
    // never sees a byte taken, nor memory a bit written, that the loader drops.
    always_comb begin
`ifdef PROG_LOADER_CHECKSUM_EN
        byte_ready = !abort && (state_q == FETCH || state_q == CHECK);
`else
        byte_ready = !abort && (state_q == FETCH);
`endif
        prog_advance = !abort && (state_q == SHIFT);
        prog_data    = prog_advance && ser_bit;
        busy         = (state_q != IDLE);
        handshake    = byte_ready && byte_valid;
        ser_load     = handshake && (state_q == FETCH);
        ser_shift    = prog_advance;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        error_d = error_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            error_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        error_d = 1'b0;
                        cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum_d  = '0;
`endif
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    if (handshake) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum_d  = csum_q ^ byte_in;
`endif
                        state_d = SHIFT;
                    end
                end
                // Reaching the program length wins over the byte boundary.
                SHIFT: begin
                    cnt_d = cnt_q + BIT_CNT_W'(1);
                    if (cnt_d == CNT_LAST) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = FINISH;
`endif
                    end else if (ser_last) begin
                        state_d = FETCH;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CHECK: begin
                    if (handshake) begin
                        if (byte_in == csum_q) begin
                            state_d = FINISH;
                        end else begin
                            error_d = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
`endif
                FINISH: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        enable_d = (state_d != IDLE);
        done_d   = (state_q == FINISH) && !abort;
    end

    assign prog_enable = enable_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a 16-bit and a 12-bit instance, each fed
// from its own host byte queue, with strobes and pulses recorded per cycle.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic       clock = 1'b0;
    logic       rst_n;
    logic       start16, abort16, valid16;
    logic [7:0] byte16;
    logic       ready16, en16, adv16, data16, busy16, done16, err16;
    logic       start12, abort12, valid12;
    logic [7:0] byte12;
    logic       ready12, en12, adv12, data12, busy12, done12, err12;

    always #5 clock = ~clock;

    prog_loader #(.PROG_BITS(16), .LSB_FIRST(1'b1)) dut16 (
        .clock(clock), .rst_n(rst_n), .start(start16), .abort(abort16),
        .byte_valid(valid16), .byte_in(byte16), .byte_ready(ready16),
        .prog_enable(en16), .prog_advance(adv16), .prog_data(data16),
        .busy(busy16), .done(done16), .error(err16)
    );

    prog_loader #(.PROG_BITS(12), .LSB_FIRST(1'b1)) dut12 (
        .clock(clock), .rst_n(rst_n), .start(start12), .abort(abort12),
        .byte_valid(valid12), .byte_in(byte12), .byte_ready(ready12),
        .prog_enable(en12), .prog_advance(adv12), .prog_data(data12),
        .busy(busy12), .done(done12), .error(err12)
    );

    logic [7:0]  q16[$];
    logic [7:0]  q12[$];
    logic [31:0] bits16, bits12;
    int checks = 0;
    int failures = 0;
    int cyc, strobes16, strobes12, dones16, dones12, done_cyc16, done_cyc12;
    int en_first16, en_last16, en_cnt16, rdy_cnt, en_stall;
    bit hold16;

    task automatic clearRec();
        bits16 = '0; bits12 = '0;
        strobes16 = 0; strobes12 = 0; dones16 = 0; dones12 = 0;
        done_cyc16 = -1; done_cyc12 = -1;
        en_first16 = -1; en_last16 = -1; en_cnt16 = 0;
    endtask

    // One clock: drive inputs after the falling edge, settle, record outputs,
    // and retire any byte the DUT will take at the coming rising edge.
    task automatic applyStimulus(input logic s16, input logic s12, input logic a16);
        @(negedge clock);
        start16 = s16;
        start12 = s12;
        abort16 = a16;
        valid16 = (q16.size() > 0) && !hold16;
        byte16  = 8'h00;
        if (valid16) byte16 = q16[0];
        valid12 = (q12.size() > 0);
        byte12  = 8'h00;
        if (valid12) byte12 = q12[0];
        #1;
        cyc = (s16 || s12) ? 0 : cyc + 1;
        if (adv16) begin
            if (strobes16 < 32) bits16[strobes16] = data16;
            strobes16++;
        end
        if (adv12) begin
            if (strobes12 < 32) bits12[strobes12] = data12;
            strobes12++;
        end
        if (done16) begin dones16++; done_cyc16 = cyc; end
        if (done12) begin dones12++; done_cyc12 = cyc; end
        if (en16) begin
            en_cnt16++;
            en_last16 = cyc;
            if (en_first16 < 0) en_first16 = cyc;
        end
        if (ready16 && valid16) q16.delete(0);
        if (ready12 && valid12) q12.delete(0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start16 = 1'b0; abort16 = 1'b0; valid16 = 1'b0; byte16 = 8'h00;
        start12 = 1'b0; abort12 = 1'b0; valid12 = 1'b0; byte12 = 8'h00;
        hold16 = 1'b0;
        cyc = 0;
        clearRec();

        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("reset_outputs16", {25'd0, busy16, en16, ready16, adv16, data16, done16, err16}, 32'd0);
        checkOutput("reset_outputs12", {25'd0, busy12, en12, ready12, adv12, data12, done12, err12}, 32'd0);
        rst_n = 1'b1;

        $display("[TB] load A5 3C, host always valid");
        q16 = '{8'hA5, 8'h3C};
        q12 = '{8'hA5, 8'h3C};
        if (CK == 1) begin q16.push_back(8'h99); q12.push_back(8'h99); end
        clearRec();
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (26) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("l1_bits16", bits16, 32'h0000_3CA5);
        checkOutput("l1_strobes16", strobes16, 16);
        checkOutput("l1_dones16", dones16, 1);
        checkOutput("l1_done_cyc16", done_cyc16, 20 + CK);
        checkOutput("l1_en_first16", en_first16, 1);
        checkOutput("l1_en_last16", en_last16, 19 + CK);
        checkOutput("l1_en_cnt16", en_cnt16, 19 + CK);
        checkOutput("l1_err16", err16, 0);
        checkOutput("l1_bits12", bits12, 32'h0000_0CA5);
        checkOutput("l1_strobes12", strobes12, 12);
        checkOutput("l1_done_cyc12", done_cyc12, 16 + CK);

        $display("[TB] load FF 0F");
        q16 = '{8'hFF, 8'h0F};
        q12 = '{8'hFF, 8'h0F};
        if (CK == 1) begin q16.push_back(8'hF0); q12.push_back(8'hF0); end
        clearRec();
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (26) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("l2_bits12", bits12, 32'h0000_0FFF);
        checkOutput("l2_strobes12", strobes12, 12);
        checkOutput("l2_dones12", dones12, 1);
        checkOutput("l2_bits16", bits16, 32'h0000_0FFF);
        checkOutput("l2_strobes16", strobes16, 16);

        $display("[TB] host stall between bytes");
        q16 = '{8'hA5, 8'h3C};
        if (CK == 1) q16.push_back(8'h99);
        clearRec();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (9) applyStimulus(1'b0, 1'b0, 1'b0);
        hold16 = 1'b1;
        rdy_cnt = 0;
        en_stall = 0;
        repeat (5) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            rdy_cnt += int'(ready16);
            en_stall += int'(en16);
        end
        hold16 = 1'b0;
        checkOutput("stall_ready", rdy_cnt, 5);
        checkOutput("stall_enable", en_stall, 5);
        checkOutput("stall_strobes", strobes16, 8);
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("stall_bits16", bits16, 32'h0000_3CA5);
        checkOutput("stall_strobes16", strobes16, 16);
        checkOutput("stall_done_cyc16", done_cyc16, 25 + CK);

        $display("[TB] abort after five strobes");
        q16 = '{8'hA5, 8'h3C};
        clearRec();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort_pre_strobes", strobes16, 5);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort_state", {29'd0, en16, busy16, err16}, 32'b001);
        repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("abort_strobes", strobes16, 5);
        checkOutput("abort_dones", dones16, 0);
        q16.delete();

        $display("[TB] restart, start while busy, reset mid-shift");
        q16 = '{8'hA5, 8'h3C};
        if (CK == 1) q16.push_back(8'h99);
        clearRec();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("restart_err_sticky", err16, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("restart_err_clear", {30'd0, busy16, err16}, 32'b10);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("busy_start_strobes", strobes16, 6);
        checkOutput("busy_start_bits", bits16, 32'h0000_0025);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("midshift_reset16", {25'd0, busy16, en16, ready16, adv16, data16, done16, err16}, 32'd0);
        rst_n = 1'b1;
        q16.delete();
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("post_reset_idle16", {25'd0, busy16, en16, ready16, adv16, data16, done16, err16}, 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        $display("[TB] checksum trailer good and bad");
        q16 = '{8'h12, 8'h34, 8'h26};
        clearRec();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (25) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ck_good_bits", bits16, 32'h0000_3412);
        checkOutput("ck_good_dones", dones16, 1);
        checkOutput("ck_good_err", err16, 0);
        q16 = '{8'h12, 8'h34, 8'h27};
        clearRec();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (25) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("ck_bad_dones", dones16, 0);
        checkOutput("ck_bad_state", {30'd0, busy16, err16}, 32'b01);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
